// File: rtl/proc_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : proc_seq_ctrl
// Brief   : Program loader and run/step/halt sequencer for the 4-bit core.
// Revision: 1.0
// ============================================================================
module proc_seq_ctrl #(
  parameter int AW = 5,
  parameter int IW = 8,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          prog_valid,
  output logic          prog_ready,
  input  logic [AW-1:0] prog_addr,
  input  logic [IW-1:0] prog_data,
  input  logic          cmd_start,
  input  logic          cmd_resume,
  input  logic          cmd_step,
  input  logic          cmd_halt,
  input  logic          bp_en,
  input  logic [AW-1:0] bp_addr,
  input  logic [AW-1:0] stop_addr,
  output logic [IW-1:0] core_instr,
  output logic          core_valid,
  output logic [AW-1:0] pc,
  output logic [2:0]    state,
  output logic          done,
  output logic [CW-1:0] instr_count
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RUN    = 3'd1,
    S_STEP   = 3'd2,
    S_PAUSED = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t        r_state;
  logic [AW-1:0] r_pc;
  logic [IW-1:0] r_instr;
  logic          r_valid;
  logic          r_done;
  logic          r_skip_bp;
  logic [CW-1:0] r_count;
  logic [IW-1:0] r_mem [2**AW];

  logic w_prog_ready;
  logic w_bp_hit;
  logic w_issue;
  logic w_at_stop;

  always_comb begin
    w_prog_ready = (r_state == S_IDLE) || (r_state == S_PAUSED) || (r_state == S_DONE);
    w_bp_hit     = bp_en && (r_pc == bp_addr) && !r_skip_bp;
    w_issue      = (r_state == S_STEP) || ((r_state == S_RUN) && !cmd_halt && !w_bp_hit);
    w_at_stop    = (r_pc == stop_addr);
  end

  // Writes are only accepted in non-issuing states, so fetch never races a write.
  always_ff @(posedge clk) begin
    if (prog_valid && w_prog_ready)
      r_mem[prog_addr] <= prog_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_IDLE;
      r_pc      <= '0;
      r_instr   <= '0;
      r_valid   <= 1'b0;
      r_done    <= 1'b0;
      r_skip_bp <= 1'b0;
      r_count   <= '0;
    end else begin
      r_valid <= w_issue;
      r_done  <= 1'b0;
      if (w_issue) begin
        r_instr   <= r_mem[r_pc];
        r_pc      <= r_pc + 1'b1;
        r_skip_bp <= 1'b0;
        if (r_count != {CW{1'b1}})
          r_count <= r_count + 1'b1;
        // Reaching the stop address wins over wrapping back into RUN.
        if (w_at_stop) begin
          r_state <= S_DONE;
          r_done  <= 1'b1;
        end else if (r_state == S_STEP) begin
          r_state <= S_PAUSED;
        end
      end else begin
        case (r_state)
          S_IDLE, S_DONE: begin
            if (cmd_start) begin
              r_state   <= S_RUN;
              r_pc      <= '0;
              r_count   <= '0;
              r_skip_bp <= 1'b0;
            end
          end
          S_RUN: begin
            if (cmd_halt || w_bp_hit)
              r_state <= S_PAUSED;
          end
          S_PAUSED: begin
            if (cmd_start) begin
              r_state   <= S_RUN;
              r_pc      <= '0;
              r_count   <= '0;
              r_skip_bp <= 1'b0;
            end else if (cmd_resume) begin
              r_state   <= S_RUN;
              r_skip_bp <= 1'b1;
            end else if (cmd_step) begin
              r_state <= S_STEP;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign prog_ready  = w_prog_ready;
  assign core_instr  = r_instr;
  assign core_valid  = r_valid;
  assign pc          = r_pc;
  assign state       = r_state;
  assign done        = r_done;
  assign instr_count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_proc_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_proc_seq_ctrl
// Brief   : Directed bench for proc_seq_ctrl with a cycle-level reference model.
// Revision: 1.0
// ============================================================================
module tb_proc_seq_ctrl;

  localparam int ST_IDLE = 0, ST_RUN = 1, ST_STEP = 2, ST_PAUSED = 3, ST_DONE = 4;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       prog_valid = 1'b0;
  logic       prog_ready;
  logic [4:0] prog_addr = '0;
  logic [7:0] prog_data = '0;
  logic       cmd_start = 1'b0, cmd_resume = 1'b0, cmd_step = 1'b0, cmd_halt = 1'b0;
  logic       bp_en = 1'b0;
  logic [4:0] bp_addr = '0;
  logic [4:0] stop_addr = 5'd3;
  logic [7:0] core_instr;
  logic       core_valid;
  logic [4:0] pc;
  logic [2:0] state;
  logic       done;
  logic [7:0] instr_count;

  int checks = 0;
  int failures = 0;
  logic [7:0] issued[$];

  proc_seq_ctrl #(.AW(5), .IW(8), .CW(8)) dut (
    .clk(clk), .reset_n(reset_n),
    .prog_valid(prog_valid), .prog_ready(prog_ready),
    .prog_addr(prog_addr), .prog_data(prog_data),
    .cmd_start(cmd_start), .cmd_resume(cmd_resume), .cmd_step(cmd_step), .cmd_halt(cmd_halt),
    .bp_en(bp_en), .bp_addr(bp_addr), .stop_addr(stop_addr),
    .core_instr(core_instr), .core_valid(core_valid), .pc(pc),
    .state(state), .done(done), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: mode/pc/count as plain integers, memory as an int array.
  int  m_mode = ST_IDLE, m_pc = 0, m_cnt = 0, m_instr = 0;
  bit  m_valid = 0, m_done = 0, m_skip = 0, m_go;
  int  m_mem [32];

  function automatic bit ready_in(input int md);
    return (md == ST_IDLE) || (md == ST_PAUSED) || (md == ST_DONE);
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_mode <= ST_IDLE; m_pc <= 0; m_cnt <= 0;
      m_valid <= 0; m_done <= 0; m_skip <= 0;
    end else begin
      m_go = 0;
      m_valid <= 0;
      m_done <= 0;
      if (prog_valid && ready_in(m_mode)) m_mem[prog_addr] <= int'(prog_data);
      if (m_mode == ST_RUN) begin
        if (cmd_halt) m_mode <= ST_PAUSED;
        else if (bp_en && m_pc == int'(bp_addr) && !m_skip) m_mode <= ST_PAUSED;
        else m_go = 1;
      end else if (m_mode == ST_STEP) begin
        m_go = 1;
      end else if (cmd_start) begin
        m_mode <= ST_RUN; m_pc <= 0; m_cnt <= 0; m_skip <= 0;
      end else if (m_mode == ST_PAUSED && cmd_resume) begin
        m_mode <= ST_RUN; m_skip <= 1;
      end else if (m_mode == ST_PAUSED && cmd_step) begin
        m_mode <= ST_STEP;
      end
      if (m_go) begin
        m_valid <= 1;
        m_instr <= m_mem[m_pc];
        m_pc    <= (m_pc + 1) % 32;
        m_cnt   <= (m_cnt < 255) ? m_cnt + 1 : 255;
        m_skip  <= 0;
        if (m_pc == int'(stop_addr)) begin
          m_mode <= ST_DONE; m_done <= 1;
        end else if (m_mode == ST_STEP) begin
          m_mode <= ST_PAUSED;
        end
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (reset_n) begin
      chk("state", 32'(state), 32'(m_mode));
      chk("pc", 32'(pc), 32'(m_pc));
      chk("core_valid", 32'(core_valid), 32'(m_valid));
      chk("done", 32'(done), 32'(m_done));
      chk("instr_count", 32'(instr_count), 32'(m_cnt));
      chk("prog_ready", 32'(prog_ready), 32'(ready_in(m_mode)));
      if (m_valid) chk("core_instr", 32'(core_instr), 32'(m_instr));
      if (core_valid) issued.push_back(core_instr);
    end
  end

  task automatic prog_write(input int a, input int d);
    prog_valid = 1'b1; prog_addr = 5'(a); prog_data = 8'(d);
    @(negedge clk);
    prog_valid = 1'b0;
  endtask

  // which: 0=start 1=resume 2=step 3=halt; held for exactly one sampling edge
  task automatic pulse(input int which);
    case (which)
      0: cmd_start = 1'b1;
      1: cmd_resume = 1'b1;
      2: cmd_step = 1'b1;
      default: cmd_halt = 1'b1;
    endcase
    @(negedge clk);
    cmd_start = 1'b0; cmd_resume = 1'b0; cmd_step = 1'b0; cmd_halt = 1'b0;
  endtask

  task automatic wait_state(input int tgt, input int budget, input string nm);
    int n = 0;
    while (int'(state) != tgt && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(nm, 32'(state), 32'(tgt));
  endtask

  task automatic run_first_program(input string tag);
    issued.delete();
    pulse(0);
    wait_state(ST_DONE, 20, {tag, "_reach_done"});
    chk({tag, "_done_pulse"}, 32'(done), 32'd1);
    chk({tag, "_issues"}, 32'(issued.size()), 32'd4);
    if (issued.size() == 4) begin
      chk({tag, "_w0"}, 32'(issued[0]), 32'h05);
      chk({tag, "_w1"}, 32'(issued[1]), 32'h16);
      chk({tag, "_w2"}, 32'(issued[2]), 32'h61);
      chk({tag, "_w3"}, 32'(issued[3]), 32'hC0);
    end
    chk({tag, "_count"}, 32'(instr_count), 32'd4);
    @(negedge clk);
    chk({tag, "_done_drop"}, 32'(done), 32'd0);
  endtask

  initial begin
    #12;
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_pc", 32'(pc), 32'd0);
    chk("rst_valid", 32'(core_valid), 32'd0);
    chk("rst_instr", 32'(core_instr), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_count", 32'(instr_count), 32'd0);
    chk("rst_ready", 32'(prog_ready), 32'd1);
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < 32; i++) prog_write(i, (i * 7 + 3) % 256);
    prog_write(0, 8'h05); prog_write(1, 8'h16); prog_write(2, 8'h61); prog_write(3, 8'hC0);

    run_first_program("t1");

    // Breakpoint at 2, then resume past it.
    bp_en = 1'b1; bp_addr = 5'd2;
    issued.delete();
    pulse(0);
    wait_state(ST_PAUSED, 20, "bp_pause");
    chk("bp_issues", 32'(issued.size()), 32'd2);
    chk("bp_pc", 32'(pc), 32'd2);
    pulse(1);
    wait_state(ST_DONE, 20, "bp_resume_done");
    chk("bp_total_issues", 32'(issued.size()), 32'd4);
    chk("bp_count", 32'(instr_count), 32'd4);

    // Single-step from pc=1.
    bp_addr = 5'd1;
    issued.delete();
    pulse(0);
    wait_state(ST_PAUSED, 20, "step_pause");
    chk("step_pc", 32'(pc), 32'd1);
    for (int k = 0; k < 3; k++) begin
      chk("step_ready_between", 32'(prog_ready), 32'd1);
      pulse(2);
      @(negedge clk);
      chk("step_valid", 32'(core_valid), 32'd1);
      chk("step_state", 32'(state), (k == 2) ? ST_DONE : ST_PAUSED);
      @(negedge clk);
      chk("step_valid_drop", 32'(core_valid), 32'd0);
    end
    chk("step_issues", 32'(issued.size()), 32'd4);
    if (issued.size() == 4) chk("step_last_word", 32'(issued[3]), 32'hC0);

    // Halt while a refused program write is offered.
    bp_en = 1'b0;
    pulse(0);
    cmd_halt = 1'b1; prog_valid = 1'b1; prog_addr = 5'd5; prog_data = 8'hAA;
    chk("halt_ready_in_run", 32'(prog_ready), 32'd0);
    @(negedge clk);
    chk("halt_state", 32'(state), 32'd3);
    chk("halt_no_issue", 32'(core_valid), 32'd0);
    chk("halt_pc", 32'(pc), 32'd0);
    chk("halt_ready_paused", 32'(prog_ready), 32'd1);
    cmd_halt = 1'b0; prog_valid = 1'b0;

    // stop_addr=0: exactly one issue.
    stop_addr = 5'd0;
    issued.delete();
    pulse(0);
    wait_state(ST_DONE, 10, "stop0_done");
    chk("stop0_issues", 32'(issued.size()), 32'd1);
    chk("stop0_count", 32'(instr_count), 32'd1);

    // stop_addr=31: full 32-entry pass, pc wraps.
    stop_addr = 5'd31;
    issued.delete();
    pulse(0);
    wait_state(ST_DONE, 50, "stop31_done");
    chk("stop31_issues", 32'(issued.size()), 32'd32);
    chk("stop31_pc_wrap", 32'(pc), 32'd0);
    chk("stop31_count", 32'(instr_count), 32'd32);
    if (issued.size() == 32) begin
      chk("stop31_w5_unwritten", 32'(issued[5]), 32'h26);
      chk("stop31_w31", 32'(issued[31]), 32'hDC);
    end

    // Long wrapped run with the stop address kept ahead of pc.
    stop_addr = 5'd16;
    pulse(0);
    for (int k = 0; k < 305; k++) begin
      stop_addr = 5'((m_pc + 16) % 32);
      @(negedge clk);
    end
    pulse(3);
    wait_state(ST_PAUSED, 5, "sat_pause");
    chk("sat_count", 32'(instr_count), 32'd255);

    // Reset in the middle of a run.
    stop_addr = 5'd3;
    pulse(0);
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_valid", 32'(core_valid), 32'd0);
    chk("arst_state", 32'(state), 32'd0);
    chk("arst_pc", 32'(pc), 32'd0);
    chk("arst_count", 32'(instr_count), 32'd0);
    @(negedge clk);
    @(negedge clk);
    chk("arst_hold_valid", 32'(core_valid), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);
    run_first_program("t6");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
